// File: rtl/raymarch_scheduler.sv
// raymarch_scheduler: frame-level scheduler that shares NUM_CORES raymarcher
// cores across one frame. Pixels are dispatched in raster order to the
// lowest-index idle core. Finished colours are collected round-robin into a
// single-entry framebuffer write register with a ready/valid handshake.
// Optional build macro: RM_SCHED_PERF_EN adds frame_cycles_out and
// core_stall_cycles_out performance counters.

// Per-core bookkeeping: busy flag plus the pixel the core is working on.
// y is kept as its row offset (y*WIDTH) so the address is a single add.
module raymarch_core_slot #(
   parameter int XW = 11,
   parameter int AW = 20
) (
   input  logic          clk_pixel_in,
   input  logic          rst_n_in,
   input  logic          start,
   input  logic          ack,
   input  logic [XW-1:0] x_in,
   input  logic [AW-1:0] row_in,
   output logic          busy,
   output logic [AW-1:0] addr
);
   logic [XW-1:0] lat_x;
   logic [AW-1:0] lat_row;

   // Set on dispatch, cleared on ack; the scheduler never does both at once.
   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy    <= 1'b0;
         lat_x   <= '0;
         lat_row <= '0;
      end else if (start) begin
         busy    <= 1'b1;
         lat_x   <= x_in;
         lat_row <= row_in;
      end else if (ack) begin
         busy    <= 1'b0;
      end
   end

   assign addr = lat_row + AW'(lat_x);
endmodule

module raymarch_scheduler #(
   parameter int WIDTH     = 1280,
   parameter int HEIGHT    = 720,
   parameter int NUM_CORES = 4
) (
   input  logic                              clk_pixel_in,
   input  logic                              rst_n_in,
   input  logic                              frame_start_in,
   output logic                              busy_out,
   output logic                              frame_done_out,
   output logic [NUM_CORES-1:0]              core_start_out,
   output logic [$clog2(WIDTH)-1:0]          core_x_out,
   output logic [$clog2(HEIGHT)-1:0]         core_y_out,
   input  logic [NUM_CORES-1:0]              core_done_in,
   input  logic [24*NUM_CORES-1:0]           core_color_in,
   output logic [NUM_CORES-1:0]              core_ack_out,
   output logic                              fb_valid_out,
   input  logic                              fb_ready_in,
   output logic [$clog2(WIDTH*HEIGHT)-1:0]   fb_addr_out,
   output logic [23:0]                       fb_data_out
`ifdef RM_SCHED_PERF_EN
   ,
   output logic [31:0]                       frame_cycles_out,
   output logic [31:0]                       core_stall_cycles_out
`endif
);
   localparam int XW    = $clog2(WIDTH);
   localparam int YW    = $clog2(HEIGHT);
   localparam int AW    = $clog2(WIDTH*HEIGHT);
   localparam int TOTAL = WIDTH*HEIGHT;
   localparam int CW    = $clog2(TOTAL+1);
   localparam int PW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                        state;
   logic [XW-1:0]                 x;
   logic [YW-1:0]                 y;
   logic [AW-1:0]                 row_base;   // y*WIDTH, tracked incrementally
   logic [CW-1:0]                 written;
   logic [PW-1:0]                 rr_ptr;
   logic [PW-1:0]                 nxt_ptr;
   logic [NUM_CORES-1:0]          busy;
   logic [NUM_CORES-1:0][AW-1:0]  slot_addr;
   logic [NUM_CORES-1:0]          elig;
   logic [NUM_CORES-1:0]          disp_oh;
   logic [NUM_CORES-1:0]          grant_oh;
   logic                          disp_vld;
   logic                          grant_vld;
   logic                          load;
   logic                          fb_hs;
   logic [23:0]                   sel_color;
   logic [AW-1:0]                 sel_addr;

   // Dispatch target: lowest-index idle core, only while pixels remain.
   always_comb begin
      disp_oh  = '0;
      disp_vld = 1'b0;
      if (state == RUN) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (!disp_vld && !busy[i]) begin
               disp_oh[i] = 1'b1;
               disp_vld   = 1'b1;
            end
         end
      end
   end

   assign elig = core_done_in & busy;

   // Round-robin pick among finished cores, scanning from rr_ptr upwards.
   always_comb begin
      grant_oh  = '0;
      grant_vld = 1'b0;
      nxt_ptr   = rr_ptr;
      sel_color = '0;
      sel_addr  = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (!grant_vld && elig[i] &&
                ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NUM_CORES))) begin
               grant_vld   = 1'b1;
               grant_oh[i] = 1'b1;
               sel_color   = core_color_in[24*i +: 24];
               sel_addr    = slot_addr[i];
               nxt_ptr     = (i == NUM_CORES-1) ? '0 : PW'(i+1);
            end
         end
      end
   end

   assign fb_hs          = fb_valid_out & fb_ready_in;
   assign load           = grant_vld & (~fb_valid_out | fb_ready_in);
   assign core_ack_out   = load ? grant_oh : '0;
   assign core_start_out = disp_oh;
   assign core_x_out     = x;
   assign core_y_out     = y;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
      raymarch_core_slot #(.XW(XW), .AW(AW)) u_slot (
         .clk_pixel_in (clk_pixel_in),
         .rst_n_in     (rst_n_in),
         .start        (disp_oh[i]),
         .ack          (core_ack_out[i]),
         .x_in         (x),
         .row_in       (row_base),
         .busy         (busy[i]),
         .addr         (slot_addr[i])
      );
   end

   // Frame FSM: raster counters, write count and frame busy/done flags.
   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
         x              <= '0;
         y              <= '0;
         row_base       <= '0;
         written        <= '0;
      end else begin
         frame_done_out <= 1'b0;
         if (fb_hs) written <= written + 1'b1;
         case (state)
            IDLE: begin
               if (frame_start_in) begin
                  state    <= RUN;
                  busy_out <= 1'b1;
                  x        <= '0;
                  y        <= '0;
                  row_base <= '0;
                  written  <= '0;
               end
            end
            RUN: begin
               if (disp_vld) begin
                  if (x == XW'(WIDTH-1)) begin
                     x <= '0;
                     if (y == YW'(HEIGHT-1)) begin
                        y        <= '0;
                        row_base <= '0;
                        state    <= DRAIN;
                     end else begin
                        y        <= y + 1'b1;
                        row_base <= row_base + AW'(WIDTH);
                     end
                  end else begin
                     x <= x + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (written == CW'(TOTAL)) begin
                  state          <= IDLE;
                  busy_out       <= 1'b0;
                  frame_done_out <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Single-entry write register: refills on the cycle its entry is taken.
   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         fb_valid_out <= 1'b0;
         fb_addr_out  <= '0;
         fb_data_out  <= '0;
         rr_ptr       <= '0;
      end else if (load) begin
         fb_valid_out <= 1'b1;
         fb_addr_out  <= sel_addr;
         fb_data_out  <= sel_color;
         rr_ptr       <= nxt_ptr;
      end else if (fb_hs) begin
         fb_valid_out <= 1'b0;
      end
   end

`ifdef RM_SCHED_PERF_EN
   // Saturating frame length and dispatch-stall counters.
   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_cycles_out      <= '0;
         core_stall_cycles_out <= '0;
      end else if (state == IDLE && frame_start_in) begin
         frame_cycles_out      <= '0;
         core_stall_cycles_out <= '0;
      end else begin
         if (busy_out && frame_cycles_out != '1)
            frame_cycles_out <= frame_cycles_out + 1'b1;
         if (state == RUN && (&busy) && core_stall_cycles_out != '1)
            core_stall_cycles_out <= core_stall_cycles_out + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_raymarch_scheduler.sv
// Bench for raymarch_scheduler on a 4x2 frame: a 2-core instance with a
// behavioural core model (auto latency or manual done control) and a 1-core
// instance with latency 5. Expected writes are queued at frame start and
// retired as the framebuffer port accepts them.
module tb_raymarch_scheduler;
   localparam int W = 4, H = 2, LAT0 = 3, LAT1 = 5;

   typedef struct packed {
      logic [2:0]  addr;
      logic [23:0] data;
   } wr_t;

   int checks = 0, errors = 0;
   int wr_cnt = 0, done_cnt = 0;
   wr_t sb[$];
   wr_t sb1[$];

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        frame_start = 1'b0, busy, fdone;
   logic [1:0]  cstart, cdone, cack;
   logic [1:0]  cx;
   logic [0:0]  cy;
   logic [47:0] ccol;
   logic        fbv, fbr = 1'b1;
   logic [2:0]  fba;
   logic [23:0] fbd;

   logic        start1 = 1'b0, busy1, done1;
   logic [0:0]  cstart1, cdone1, cack1;
   logic [1:0]  cx1;
   logic [0:0]  cy1;
   logic [23:0] ccol1;
   logic        fbv1, fbr1 = 1'b1;
   logic [2:0]  fba1;
   logic [23:0] fbd1;

`ifdef RM_SCHED_PERF_EN
   logic [31:0] fc0, sc0, fc1, sc1;
`endif

   always #5 clk = ~clk;

   raymarch_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(2)) dut (
      .clk_pixel_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
      .busy_out(busy), .frame_done_out(fdone), .core_start_out(cstart),
      .core_x_out(cx), .core_y_out(cy), .core_done_in(cdone),
      .core_color_in(ccol), .core_ack_out(cack), .fb_valid_out(fbv),
      .fb_ready_in(fbr), .fb_addr_out(fba), .fb_data_out(fbd)
`ifdef RM_SCHED_PERF_EN
      , .frame_cycles_out(fc0), .core_stall_cycles_out(sc0)
`endif
   );

   raymarch_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(1)) dut1 (
      .clk_pixel_in(clk), .rst_n_in(rst_n), .frame_start_in(start1),
      .busy_out(busy1), .frame_done_out(done1), .core_start_out(cstart1),
      .core_x_out(cx1), .core_y_out(cy1), .core_done_in(cdone1),
      .core_color_in(ccol1), .core_ack_out(cack1), .fb_valid_out(fbv1),
      .fb_ready_in(fbr1), .fb_addr_out(fba1), .fb_data_out(fbd1)
`ifdef RM_SCHED_PERF_EN
      , .frame_cycles_out(fc1), .core_stall_cycles_out(sc1)
`endif
   );

   // Core model for the 2-core instance; colour is {x,y,8'hAA}.
   logic       manual = 1'b0;
   logic [1:0] man_done = 2'b00;
   logic [1:0] pend;
   int         cnt [2];
   logic [1:0] mx [2];
   logic [0:0] my [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= 0; mx[i] <= '0; my[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (cstart[i]) begin
               pend[i] <= 1'b1; cnt[i] <= 1; mx[i] <= cx; my[i] <= cy;
            end else if (cack[i]) begin
               pend[i] <= 1'b0;
            end else if (pend[i] && cnt[i] < LAT0) begin
               cnt[i] <= cnt[i] + 1;
            end
         end
      end
   end

   always_comb begin
      cdone = '0;
      ccol  = '0;
      for (int i = 0; i < 2; i++) begin
         cdone[i] = pend[i] && (manual ? man_done[i] : (cnt[i] >= LAT0));
         ccol[24*i +: 24] = {8'(mx[i]), 8'(my[i]), 8'hAA};
      end
   end

   // Core model for the 1-core instance.
   logic       pend1;
   int         cnt1;
   logic [1:0] mx1;
   logic [0:0] my1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend1 <= 1'b0; cnt1 <= 0; mx1 <= '0; my1 <= '0;
      end else if (cstart1[0]) begin
         pend1 <= 1'b1; cnt1 <= 1; mx1 <= cx1; my1 <= cy1;
      end else if (cack1[0]) begin
         pend1 <= 1'b0;
      end else if (pend1 && cnt1 < LAT1) begin
         cnt1 <= cnt1 + 1;
      end
   end

   assign cdone1[0] = pend1 && (cnt1 >= LAT1);
   assign ccol1     = {8'(mx1), 8'(my1), 8'hAA};

   // Monitor: retire writes against the scoreboard, check hold-while-stalled
   // and that busy falls in the frame_done cycle.
   logic        stall_prev = 1'b0, prev_busy = 1'b0;
   logic [2:0]  p_addr;
   logic [23:0] p_data;
   int          hit;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
         prev_busy  = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (fbv !== 1'b1 || fba !== p_addr || fbd !== p_data) begin
               errors++;
               $display("FAIL hold_stalled: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                        fbv, fba, fbd, p_addr, p_data);
            end
         end
         if (fbv && fbr) begin
            hit = -1;
            for (int i = 0; i < sb.size(); i++) if (sb[i].addr == fba) hit = i;
            checks++;
            wr_cnt++;
            if (hit < 0) begin
               errors++;
               $display("FAIL write_expected: addr=%0d data=%h written, required a pending pixel at that address",
                        fba, fbd);
            end else begin
               checks++;
               if (fbd !== sb[hit].data) begin
                  errors++;
                  $display("FAIL write_data: addr=%0d data=%h, required %h", fba, fbd, sb[hit].data);
               end
               sb.delete(hit);
            end
         end
         if (fdone) begin
            done_cnt++;
            checks++;
            if (busy !== 1'b0 || prev_busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_fall: busy=%b prev_busy=%b at frame_done, required 0 and 1", busy, prev_busy);
            end
         end
         stall_prev = fbv && !fbr;
         p_addr     = fba;
         p_data     = fbd;
         prev_busy  = busy;
      end
   end

   task automatic push_frame();
      for (int p = 0; p < W*H; p++)
         sb.push_back('{addr: 3'(p), data: {8'(p % W), 8'(p / W), 8'hAA}});
   endtask

   // Start a frame on the 2-core instance and run until frame_done.
   task automatic run_frame(input int rdiv, input int mid_at, output bit to);
      int cyc;
      push_frame();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      cyc = 0;
      to  = 1'b1;
      while (cyc < 2000) begin
         fbr         = (rdiv <= 1) ? 1'b1 : (cyc % rdiv == 0);
         frame_start = (cyc == mid_at);
         @(negedge clk);
         if (fdone) begin
            to = 1'b0;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
      fbr         = 1'b1;
      frame_start = 1'b0;
   endtask

   task automatic check_frame_end(input string tag, input bit to);
      checks++;
      if (to) begin errors++; $display("FAIL %s_timeout: frame_done not seen, required within 2000 cycles", tag); end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_cnt != W*H) begin errors++; $display("FAIL %s_writes: %0d, required %0d", tag, wr_cnt, W*H); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL %s_missing: %0d pixels unwritten, required 0", tag, sb.size()); end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count: %0d, required 1", tag, done_cnt); end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, fdone, cstart, cack, fbv, fba, fbd, cx, cy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b start=%b ack=%b valid=%b addr=%0d data=%h, required all 0",
                  busy, fdone, cstart, cack, fbv, fba, fbd);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, fdone, cstart, fbv} !== '0 || {busy1, done1, cstart1, fbv1} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b start=%b valid=%b busy1=%b, required 0", busy, cstart, fbv, busy1);
      end
   endtask

   task automatic test_basic();
      bit to;
      wr_cnt = 0; done_cnt = 0;
      run_frame(1, -1, to);
      check_frame_end("basic", to);
   endtask

   task automatic test_stall();
      bit to;
      wr_cnt = 0; done_cnt = 0;
      run_frame(3, -1, to);
      check_frame_end("stall", to);
   endtask

   task automatic test_mid_start();
      bit to;
      wr_cnt = 0; done_cnt = 0;
      run_frame(1, 5, to);
      check_frame_end("mid_start", to);
      repeat (20) @(negedge clk);
      checks++;
      if (wr_cnt != W*H || done_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_start_quiet: writes=%0d done=%0d busy=%b, required %0d 1 0", wr_cnt, done_cnt, busy, W*H);
      end
   endtask

   task automatic test_arbitration();
      bit to;
      logic [1:0] req [6];
      logic [1:0] exp [6];
      req = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11};
      exp = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wr_cnt = 0; done_cnt = 0;
      manual = 1'b1; man_done = 2'b00;
      push_frame();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 6; s++) begin
         man_done = req[s];
         @(negedge clk);
         checks++;
         if (cack !== exp[s]) begin
            errors++;
            $display("FAIL arb_step%0d: ack=%b with done=%b, required %b", s, cack, req[s], exp[s]);
         end
         @(posedge clk); #1;
      end
      man_done = 2'b01;
      @(negedge clk);
      checks++;
      if (cack !== 2'b01) begin errors++; $display("FAIL arb_step6: ack=%b, required 01", cack); end
      @(posedge clk); #1;
      man_done = 2'b00;
      manual   = 1'b0;
      to = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (fdone) begin to = 1'b0; break; end
      end
      check_frame_end("arb", to);
   endtask

   task automatic test_async_reset();
      bit to;
      wr_cnt = 0; done_cnt = 0;
      push_frame();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, fdone, cstart, cack, fbv, fba, fbd, cx, cy} !== '0) begin
         errors++;
         $display("FAIL async_reset: busy=%b start=%b ack=%b valid=%b addr=%0d data=%h x=%0d y=%0d, required all 0",
                  busy, cstart, cack, fbv, fba, fbd, cx, cy);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: done=%0d busy=%b, required 0 0", done_cnt, busy);
      end
      sb.delete();
      wr_cnt = 0;
      run_frame(1, -1, to);
      check_frame_end("after_reset", to);
   endtask

   task automatic test_single_core();
      int  busy_cyc;
      bit  fin;
      wr_t e;
      for (int p = 0; p < W*H; p++)
         sb1.push_back('{addr: 3'(p), data: {8'(p % W), 8'(p / W), 8'hAA}});
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      busy_cyc = 0;
      fin      = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
         @(negedge clk);
         if (busy1) busy_cyc++;
         if (fbv1 && fbr1) begin
            checks++;
            if (sb1.size() == 0) begin
               errors++;
               $display("FAIL single_extra: addr=%0d written, required no further writes", fba1);
            end else begin
               e = sb1.pop_front();
               if (fba1 !== e.addr || fbd1 !== e.data) begin
                  errors++;
                  $display("FAIL single_write: addr=%0d data=%h, required addr=%0d data=%h", fba1, fbd1, e.addr, e.data);
               end
            end
         end
         if (done1) fin = 1'b1;
      end
      checks++;
      if (!fin) begin errors++; $display("FAIL single_timeout: frame_done not seen, required within 2000 cycles"); end
      repeat (3) @(negedge clk);
      checks++;
      if (sb1.size() != 0) begin errors++; $display("FAIL single_missing: %0d, required 0", sb1.size()); end
`ifdef RM_SCHED_PERF_EN
      checks++;
      if (fc1 !== 32'(busy_cyc)) begin
         errors++;
         $display("FAIL perf_frame_cycles: %0d, required %0d", fc1, busy_cyc);
      end
      checks++;
      if (sc1 == 32'd0) begin errors++; $display("FAIL perf_stall_cycles: %0d, required nonzero", sc1); end
`endif
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at 400us, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_mid_start();
      test_arbitration();
      test_async_reset();
      test_single_core();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
